// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux scan sequencer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } scan_state_t;

  localparam int SETTLE_W = 4;

  // A single-code select bus still needs one wire.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_settle_timer.sv
// Settle-window down-counter: reloads while load is high, otherwise counts to zero.
module mux_scan_settle_timer
  import mux_scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] value,
  output logic                expired
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - SETTLE_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the data-select stage through every code and packs the samples into one word.
// Optional complement check of mux_in_n enabled by MUX_SCAN_COMPLEMENT_CHECK_EN.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int NUM_SEL    = 8,
  parameter int SEL_W      = sel_width(NUM_SEL),
  parameter int SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  output logic [SEL_W-1:0]   sel,
  output logic               mux_dis,
  input  logic               mux_in,
  input  logic               mux_in_n,
  output logic               word_valid,
  input  logic               word_ready,
  output logic [NUM_SEL-1:0] word_data,
  output logic               word_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  localparam logic [SEL_W-1:0]    LAST_SEL    = SEL_W'(NUM_SEL - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = (SETTLE_CYC == 0) ? '0 : SETTLE_W'(SETTLE_CYC - 1);
  localparam scan_state_t         CODE_ENTRY  = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

  scan_state_t state;
  logic        settle_done;

  mux_scan_settle_timer u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state != SETTLE),
    .value   (SETTLE_LOAD),
    .expired (settle_done)
  );

  // Gated by rst so the port reads low while reset is held.
  assign start_ready = (state == IDLE) && !rst;

`ifndef MUX_SCAN_COMPLEMENT_CHECK_EN
  logic unused_mux_in_n;
  assign unused_mux_in_n = mux_in_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      mux_dis    <= 1'b1;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            state     <= CODE_ENTRY;
            mux_dis   <= 1'b0;
            sel       <= '0;
            word_data <= '0;
            word_err  <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          word_data[sel] <= mux_in;
`ifdef MUX_SCAN_COMPLEMENT_CHECK_EN
          if (mux_in_n == mux_in) begin
            word_err <= 1'b1;
          end
`endif
          if (sel == LAST_SEL) begin
            state      <= DONE;
            mux_dis    <= 1'b1;
            sel        <= '0;
            word_valid <= 1'b1;
          end else begin
            sel   <= sel + SEL_W'(1);
            state <= CODE_ENTRY;
          end
        end
        DONE: begin
          if (word_ready) begin
            state      <= IDLE;
            word_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: default build plus a 4-code, zero-settle instance.
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_COMPLEMENT_CHECK_EN
  localparam logic CMP_EN = 1'b1;
`else
  localparam logic CMP_EN = 1'b0;
`endif
  localparam int SETTLE = 2;
  localparam int LAT8   = 8 * (SETTLE + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic       start_valid, start_ready, mux_dis, mux_in, mux_in_n;
  logic       word_valid, word_ready, word_err;
  logic [2:0] sel;
  logic [7:0] word_data;
  logic [7:0] pat;
  int         force_code;

  // Stage model: true output forced low while disabled; complement optionally broken at one code.
  assign mux_in   = mux_dis ? 1'b0 : pat[sel];
  assign mux_in_n = (force_code >= 0 && int'(sel) == force_code) ? mux_in : ~mux_in;

  mux_scan_sequencer dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .sel(sel), .mux_dis(mux_dis), .mux_in(mux_in), .mux_in_n(mux_in_n),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data), .word_err(word_err)
  );

  // ---------------- 4-code, zero-settle instance ----------------
  logic       start_valid4, start_ready4, mux_dis4, mux_in4, mux_in_n4;
  logic       word_valid4, word_ready4, word_err4;
  logic [1:0] sel4;
  logic [3:0] word_data4;
  logic [3:0] pat4;

  assign mux_in4   = mux_dis4 ? 1'b0 : pat4[sel4];
  assign mux_in_n4 = ~mux_in4;

  mux_scan_sequencer #(.NUM_SEL(4), .SETTLE_CYC(0)) dut4 (
    .clk(clk), .rst(rst), .start_valid(start_valid4), .start_ready(start_ready4),
    .sel(sel4), .mux_dis(mux_dis4), .mux_in(mux_in4), .mux_in_n(mux_in_n4),
    .word_valid(word_valid4), .word_ready(word_ready4), .word_data(word_data4), .word_err(word_err4)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [4:0] exp4_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Words are taken on the negedge before the handshake edge; inputs change only just after posedge.
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", {23'd0, word_err, word_data}, 32'h1ff);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("word_data", {24'd0, word_data}, {24'd0, e[7:0]});
        check("word_err", {31'd0, word_err}, {31'd0, e[8]});
      end
    end
    if (!rst && word_valid4 && word_ready4) begin
      if (exp4_q.size() == 0) begin
        check("sb4_unexpected_word", {27'd0, word_err4, word_data4}, 32'h1f);
      end else begin
        logic [4:0] e4;
        e4 = exp4_q.pop_front();
        check("word_data4", {28'd0, word_data4}, {28'd0, e4[3:0]});
        check("word_err4", {31'd0, word_err4}, {31'd0, e4[4]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a scan on the default instance and returns in the cycle word_valid is first seen.
  task automatic run_scan(input logic [7:0] p, input int fc, input logic [7:0] ew, input logic ee);
    int lat;
    bit walk_ok;
    pat        = p;
    force_code = fc;
    check("start_ready_idle", {31'd0, start_ready}, 32'd1);
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    exp_q.push_back({ee, ew});
    lat     = 0;
    walk_ok = 1'b1;
    while (!word_valid && lat < 200) begin
      if (sel !== 3'(lat / (SETTLE + 1)) || mux_dis !== 1'b0 || start_ready !== 1'b0) walk_ok = 1'b0;
      step();
      lat++;
    end
    check("sel_walk", {31'd0, walk_ok}, 32'd1);
    check("latency", lat, LAT8);
    check("mux_dis_done", {31'd0, mux_dis}, 32'd1);
    check("sel_done", {29'd0, sel}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] pat;
    int         fc;
    logic [7:0] exp_word;
    logic       exp_err;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [7:0] r;
    int lat;
    bit ok_data, ok_valid, ok_ready, ok_idle;

    vecs[0] = '{8'hA5, -1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, -1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, -1, 8'hFF, 1'b0};
    vecs[3] = '{8'h3C, -1, 8'h3C, 1'b0};
    r = 8'($urandom_range(0, 255));
    vecs[4] = '{r, -1, r, 1'b0};
    r = 8'($urandom_range(0, 255));
    vecs[5] = '{r, -1, r, 1'b0};
    vecs[6] = '{8'h5A, 3, 8'h5A, CMP_EN};
    vecs[7] = '{8'hC3, -1, 8'hC3, 1'b0};

    rst = 1'b1;
    start_valid = 1'b0; word_ready = 1'b1; pat = 8'h00; force_code = -1;
    start_valid4 = 1'b0; word_ready4 = 1'b1; pat4 = 4'h0;

    // Reset values while reset is held
    step(); step();
    check("rst_mux_dis", {31'd0, mux_dis}, 32'd1);
    check("rst_start_ready", {31'd0, start_ready}, 32'd0);
    check("rst_word_data", {24'd0, word_data}, 32'd0);
    check("rst_word_valid", {31'd0, word_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("first_cycle_start_ready", {31'd0, start_ready}, 32'd1);

    // Idle with no request stays idle
    ok_idle = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mux_dis !== 1'b1 || sel !== 3'd0 || start_ready !== 1'b1 || word_valid !== 1'b0) ok_idle = 1'b0;
    end
    check("idle_hold", {31'd0, ok_idle}, 32'd1);

    // Table of scans with word_ready held high
    for (int i = 0; i < 8; i++) begin
      word_ready = 1'b1;
      run_scan(vecs[i].pat, vecs[i].fc, vecs[i].exp_word, vecs[i].exp_err);
      step();
      check("post_word_idle", {31'd0, start_ready}, 32'd1);
    end
    force_code = -1;

    // Backpressure with ignored start requests
    word_ready = 1'b0;
    run_scan(8'hA5, -1, 8'hA5, 1'b0);
    ok_data = 1'b1; ok_valid = 1'b1; ok_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start_valid = (i % 2) == 0;
      step();
      if (word_data !== 8'hA5) ok_data = 1'b0;
      if (word_valid !== 1'b1) ok_valid = 1'b0;
      if (start_ready !== 1'b0 || mux_dis !== 1'b1) ok_ready = 1'b0;
    end
    check("bp_word_held", {31'd0, ok_data}, 32'd1);
    check("bp_valid_held", {31'd0, ok_valid}, 32'd1);
    check("bp_start_ignored", {31'd0, ok_ready}, 32'd1);
    start_valid = 1'b0;
    word_ready  = 1'b1;
    step();
    check("bp_release_valid", {31'd0, word_valid}, 32'd0);
    run_scan(8'h96, -1, 8'h96, 1'b0);
    step();

    // Four codes, no settle interval
    pat4 = 4'b1001;
    check("start_ready4", {31'd0, start_ready4}, 32'd1);
    start_valid4 = 1'b1;
    step();
    start_valid4 = 1'b0;
    exp4_q.push_back({1'b0, 4'h9});
    lat = 0;
    ok_idle = 1'b1;
    while (!word_valid4 && lat < 100) begin
      if (sel4 !== 2'(lat) || mux_dis4 !== 1'b0) ok_idle = 1'b0;
      step();
      lat++;
    end
    check("sel4_walk", {31'd0, ok_idle}, 32'd1);
    check("latency4", lat, 4);
    step();

    // Reset in the middle of a scan, then a clean rescan
    pat = 8'hA5;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    lat = 0;
    while (sel !== 3'd5 && lat < 100) begin
      step();
      lat++;
    end
    check("reach_sel5", {29'd0, sel}, 32'd5);
    rst = 1'b1;
    #1;
    check("midrst_mux_dis", {31'd0, mux_dis}, 32'd1);
    check("midrst_sel", {29'd0, sel}, 32'd0);
    check("midrst_word_data", {24'd0, word_data}, 32'd0);
    check("midrst_start_ready", {31'd0, start_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    run_scan(8'h6B, -1, 8'h6B, 1'b0);
    step();
    step();

    check("sb_drain", exp_q.size(), 32'd0);
    check("sb4_drain", exp4_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
